// File: rtl/fpcvt_pkg.sv
// Shared constants, FSM state type and magnitude helper for the FPCVT scheduler slice.
package fpcvt_pkg;

    localparam int DW = 12;
    localparam int EW = 3;
    localparam int FW = 4;
    localparam int unsigned SAT_TH = 1984;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_RESP
    } state_t;

    // |d| with the single unrepresentable negative value clamped to the largest positive one
    function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] d);
        if (!d[DW-1])
            return d;
        else if (d == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        else
            return -d;
    endfunction

endpackage

// File: rtl/fpcvt_rr_sched_if.sv
// Request/response bundle between sample producers, the FPCVT scheduler and its consumer.
// sat_cnt exists only when FPCVT_SAT_CNT_EN is defined.
interface fpcvt_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import fpcvt_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    ack;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic               S;
    logic [EW-1:0]      E;
    logic [FW-1:0]      F;
`ifdef FPCVT_SAT_CNT_EN
    logic [7:0]         sat_cnt;
`endif

`ifdef FPCVT_SAT_CNT_EN
    modport master (
        output req, din, resp_ready,
        input  ack, resp_valid, resp_id, S, E, F, sat_cnt
    );
    modport slave (
        input  req, din, resp_ready,
        output ack, resp_valid, resp_id, S, E, F, sat_cnt
    );
`else
    modport master (
        output req, din, resp_ready,
        input  ack, resp_valid, resp_id, S, E, F
    );
    modport slave (
        input  req, din, resp_ready,
        output ack, resp_valid, resp_id, S, E, F
    );
`endif

endinterface

// File: rtl/fpcvt_rr_sched_fpcvt.sv
// FPCVT: 12-bit two's complement to sign / 3-bit exponent / 4-bit significand, round half-up.
module fpcvt
    import fpcvt_pkg::*;
(
    input  logic [DW-1:0] d,
    output logic          s,
    output logic [EW-1:0] e,
    output logic [FW-1:0] f
);

    logic [DW-1:0] mag;
    logic [DW-1:0] sh;
    logic [FW:0]   sum;
    int unsigned   hi;
    int unsigned   ex;

    always_comb begin
        mag = mag_of(d);
        s   = d[DW-1];
        hi  = 0;
        for (int unsigned k = 0; k < DW; k++) begin
            if (mag[k]) hi = k;
        end
        ex  = (hi > FW - 1) ? hi - (FW - 1) : 0;
        sh  = '0;
        sum = '0;
        e   = '0;
        f   = '0;
        if (ex == 0) begin
            f = mag[FW-1:0];
        end else begin
            // sh[FW:1] is the significand starting at the leading one, sh[0] the round bit
            sh  = mag >> (ex - 1);
            sum = {1'b0, sh[FW:1]} + {{FW{1'b0}}, sh[0]};
            if (!sum[FW]) begin
                e = EW'(ex);
                f = sum[FW-1:0];
            end else if (ex == (1 << EW) - 1) begin
                e = '1;
                f = '1;
            end else begin
                e = EW'(ex + 1);
                f = {1'b1, {(FW-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/fpcvt_rr_sched.sv
// Round-robin scheduler sharing one FPCVT converter among NREQ requesters.
// Optional saturation counter output enabled by defining FPCVT_SAT_CNT_EN.
module fpcvt_rr_sched
    import fpcvt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic              clk,
    input logic              rst,
    fpcvt_rr_sched_if.slave  bus
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [IDW-1:0]  pick;
    logic [DW-1:0]   op_q, op_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            valid_q, valid_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            s_q, s_d;
    logic [EW-1:0]   e_q, e_d;
    logic [FW-1:0]   f_q, f_d;
    logic            cs;
    logic [EW-1:0]   ce;
    logic [FW-1:0]   cf;

    // First set request at or after the pointer, wrapping modulo NREQ
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        w     = p;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned j;
            j = k + p;
            if (j >= NREQ) j = j - NREQ;
            if (!found && r[j]) begin
                w     = IDW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    fpcvt u_fpcvt (
        .d (op_q),
        .s (cs),
        .e (ce),
        .f (cf)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        ack_d   = '0;
        valid_d = valid_q;
        id_d    = id_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        pick    = rr_pick(bus.req, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    win_d   = pick;
                    op_d    = bus.din[DW*pick +: DW];
                    ack_d   = NREQ'(1) << pick;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                id_d    = win_q;
                s_d     = cs;
                e_d     = ce;
                f_d     = cf;
                valid_d = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = id_q;
    assign bus.S          = s_q;
    assign bus.E          = e_q;
    assign bus.F          = f_q;

`ifdef FPCVT_SAT_CNT_EN
    logic [7:0] sat_cnt_q;
    logic       sat_hit;

    assign sat_hit = (state_q == ST_CONV) && (mag_of(op_q) >= DW'(SAT_TH));

    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt_q <= '0;
        else if (sat_hit && sat_cnt_q != '1)
            sat_cnt_q <= sat_cnt_q + 1'b1;
    end

    assign bus.sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fpcvt_rr_sched.sv
// Scoreboard bench for fpcvt_rr_sched: directed operands with hand-computed S/E/F and grant order.
module tb_fpcvt_rr_sched;

    logic clk;
    logic rst;

    fpcvt_rr_sched_if #(.NREQ(4), .IDW(2)) bus ();

    fpcvt_rr_sched #(.NREQ(4), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [1:0] id;
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
    } exp_t;

    exp_t rq[$];
    int   aq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_hs = -1;
    logic spacing_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic [11:0] d, input logic s, input logic [2:0] e,
                         input logic [3:0] f);
        exp_t x;
        x.id = i[1:0];
        x.s  = s;
        x.e  = e;
        x.f  = f;
        bus.din[12*i +: 12] = d;
        bus.req[i] = 1'b1;
        aq.push_back(i);
        rq.push_back(x);
    endtask

    task automatic drain(input int max);
        int c;
        c = 0;
        while ((rq.size() != 0 || aq.size() != 0) && c < max) begin
            @(negedge clk);
            c++;
        end
        chk("drain_pending", rq.size() + aq.size(), 0);
    endtask

    task automatic one(input int i, input logic [11:0] d, input logic s, input logic [2:0] e,
                       input logic [3:0] f);
        @(posedge clk); #1;
        issue(i, d, s, e, f);
        drain(50);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ack"}, bus.ack, 0);
        chk({name, "_valid"}, bus.resp_valid, 0);
        chk({name, "_fields"}, {bus.resp_id, bus.S, bus.E, bus.F}, 0);
`ifdef FPCVT_SAT_CNT_EN
        chk({name, "_satcnt"}, bus.sat_cnt, 0);
`endif
    endtask

    // Monitor: grants and results are checked against the queues whenever the DUT presents them
    initial begin
        exp_t x;
        int   a;
        forever begin
            @(negedge clk);
            if (bus.ack != 0) begin
                if (aq.size() == 0) begin
                    chk("ack_unexpected", bus.ack, 0);
                end else begin
                    a = aq.pop_front();
                    chk("ack_grant", bus.ack, 32'd1 << a);
                end
                bus.req = bus.req & ~bus.ack;
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (rq.size() == 0) begin
                    chk("resp_unexpected", bus.resp_valid, 0);
                end else begin
                    x = rq.pop_front();
                    chk("resp_result", {bus.resp_id, bus.S, bus.E, bus.F}, x);
                end
                if (spacing_chk) begin
                    if (last_hs >= 0) chk("resp_spacing", cyc - last_hs, 3);
                    last_hs = cyc;
                end
            end
        end
    end

    initial begin
        int c;
        rst            = 1'b1;
        bus.req        = '0;
        bus.din        = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");

        // Basic conversion with latency: 45 -> E=2, F=1011
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 12'b000000101101, 1'b0, 3'd2, 4'b1011);
        @(negedge clk);
        chk("lat_ack_early", bus.ack, 0);
        @(negedge clk);
        chk("lat_ack", bus.ack, 4'b0001);
        @(negedge clk);
        chk("lat_valid", bus.resp_valid, 1);
        drain(50);

        // Fresh pointer, all four requesting: grants 0,1,2,3 three cycles apart
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        spacing_chk = 1'b1;
        last_hs = -1;
        issue(0, 12'd5,    1'b0, 3'd0, 4'b0101);
        issue(1, 12'd100,  1'b0, 3'd3, 4'b1101);
        issue(2, 12'hFFF,  1'b1, 3'd0, 4'b0001);
        issue(3, 12'd1000, 1'b0, 3'd7, 4'b1000);
        drain(60);
        spacing_chk = 1'b0;
        @(posedge clk); #1;
        issue(0, 12'd16,   1'b0, 3'd1, 4'b1000);
        issue(2, 12'hC18,  1'b1, 3'd7, 4'b1000);
        drain(50);

        // Rounding overflow and zero
        one(3, 12'b000000111111, 1'b0, 3'd3, 4'b1000);
        one(2, 12'd0,            1'b0, 3'd0, 4'b0000);

        // Backpressure: result held, pending request not granted
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        issue(1, 12'b111001001010, 1'b1, 3'd5, 4'b1110);
        c = 0;
        while (!bus.resp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        issue(3, 12'b000000111111, 1'b0, 3'd3, 4'b1000);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", bus.resp_valid, 1);
            chk("bp_fields", {bus.resp_id, bus.S, bus.E, bus.F}, {2'd1, 1'b1, 3'd5, 4'b1110});
            chk("bp_ack", bus.ack, 0);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", bus.resp_valid, 0);
        drain(50);

        // Saturation boundaries
        one(0, 12'b011111111111, 1'b0, 3'd7, 4'b1111);
        one(1, 12'b100000000000, 1'b1, 3'd7, 4'b1111);
        one(2, 12'd1983,         1'b0, 3'd7, 4'b1111);
`ifdef FPCVT_SAT_CNT_EN
        chk("sat_cnt", bus.sat_cnt, 2);
`endif

        // Reset while converting: result discarded, pointer back to 0
        @(posedge clk); #1;
        issue(2, 12'd45, 1'b0, 3'd2, 4'b1011);
        c = 0;
        while (bus.ack == 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        rst = 1'b1;
        rq.delete();
        @(negedge clk);
        chk_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, 12'd63,  1'b0, 3'd3, 4'b1000);
        issue(3, 12'd100, 1'b0, 3'd3, 4'b1101);
        drain(50);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
